calculate_fare_sub: RTL and testbench
=====================================

// Module: calculate_fare_sub
// PURPOSE
//  Reader/consumer side of the taximeter distance bus. Samples the 16-bit
//  odometer `distance` (100 m units) produced by the distance block and bills
//  every new unit. Also bills waiting time while `park` is high.
//  Drives the fare and trip distance to the display path.
// PARAMETERS
//  BASE_FARE      100   fare at trip start, 0.1-yuan units (10.0 yuan)
//  BASE_DIST      30    units included in BASE_FARE (3.0 km)
//  PER_UNIT_FARE  2     added per billed unit beyond BASE_DIST
//  WAIT_TICKS     1000  clk cycles of parked waiting per wait charge
//  WAIT_FARE      1     added per completed WAIT_TICKS interval
//  FARE_MAX       9999  saturation ceiling for fare (4-digit display)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  restart_n  in   1   asynchronous, active-low reset
//  park       in   1   vehicle parked (waiting), level
//  new_trip   in   1   synchronous start/restart-trip pulse
//  end_trip   in   1   synchronous end-trip pulse, freezes outputs
//  distance   in   16  odometer from distance block, monotonic mod 2^16
//  fare       out  16  current fare, 0.1-yuan units, binary
//  trip_dist  out  16  units billed this trip (saturates at 16'hFFFF)
//  in_trip    out  1   1 while state==TRIP
// BEHAVIOUR
//  Reset (restart_n=0, async):
//   - state=IDLE; fare=0; trip_dist=0; in_trip=0; wait_cnt=0.
//   - billed_pos loads `distance` on the first clk edge after release.
//  billed_pos is an internal 16-bit pointer that chases `distance`:
//   - If billed_pos!=distance, billed_pos<=billed_pos+1 (mod 2^16). One unit
//     per cycle; bursts are caught up over successive cycles.
//   - Wrap 16'hFFFF->0 is a normal +1 step.
//  State IDLE:
//   - billed_pos<=distance every cycle; no billing; fare/trip_dist hold.
//   - new_trip -> TRIP.
//  State TRIP:
//   - Entry (from any state via new_trip): fare<=BASE_FARE; trip_dist<=0;
//     wait_cnt<=0; billed_pos<=distance. Motion before entry is not billed.
//   - Unit step (billed_pos!=distance):
//     - trip_dist+1.
//     - If the new trip_dist>BASE_DIST, fare+=PER_UNIT_FARE.
//     - wait_cnt holds.
//   - Wait step (park=1 and billed_pos==distance): wait_cnt+1.
//     - At wait_cnt==WAIT_TICKS-1: wait_cnt<=0 and fare+=WAIT_FARE.
//   - park=0 and caught up: wait_cnt holds; partial interval is kept.
//   - fare saturates at FARE_MAX; it never wraps.
//   - end_trip -> HOLD.
//  State HOLD:
//   - fare/trip_dist frozen; billed_pos<=distance every cycle.
//   - new_trip -> TRIP with entry actions.
//  Priority and latency:
//   - Simultaneous new_trip and end_trip: new_trip wins.
//   - Unit step beats wait step in the same cycle; at most one fare change
//     per cycle.
//   - fare updates in the cycle after billed_pos detects the difference
//     (registered output, 1-cycle latency per unit).
//   - in_trip is registered and equals (state==TRIP).
//  Async reset mid-trip: immediate return to reset values; the trip is lost.
// TESTING
//  - Reset, new_trip, distance 0->30 in +1 steps -> fare stays 100,
//    trip_dist=30; distance 31 -> fare=102 one cycle later.
//  - In TRIP at distance 40, step distance directly to 45 -> five consecutive
//    +PER_UNIT_FARE updates over 5 cycles; ends with trip_dist+5 and fare+10.
//  - park=1, distance static for 3000 cycles -> fare +3 (one per 1000
//    cycles); drop park at 1500 -> +1 only, wait_cnt kept at 500.
//  - distance wraps 16'hFFFE->16'h0001 -> 3 units billed, no spurious jump.
//  - Force fare to 9998 then bill 2 units -> fare=9999 and holds; end_trip ->
//    further distance/park changes leave fare=9999.
//  - Pull restart_n low mid-trip -> fare=0, in_trip=0 immediately. Also
//    assert new_trip+end_trip together -> TRIP with fare=100.

Source files
------------

// File: rtl/calculate_fare_sub.sv
// Taximeter fare engine: chases the odometer one 100 m unit per cycle and bills distance plus parked waiting time.
// Latency: fare/trip_dist registered, one billed unit per cycle; no backpressure, bursts are caught up over successive cycles.
module calculate_fare_sub #(
  parameter int unsigned BASE_FARE     = 100,
  parameter int unsigned BASE_DIST     = 30,
  parameter int unsigned PER_UNIT_FARE = 2,
  parameter int unsigned WAIT_TICKS    = 1000,
  parameter int unsigned WAIT_FARE     = 1,
  parameter int unsigned FARE_MAX      = 9999
) (
  input  logic        clk,
  input  logic        restart_n,
  input  logic        park,
  input  logic        new_trip,
  input  logic        end_trip,
  input  logic [15:0] distance,
  output logic [15:0] fare,
  output logic [15:0] trip_dist,
  output logic        in_trip
);

  localparam int unsigned WCW = $clog2(WAIT_TICKS + 1);
  localparam logic [15:0]    BASE_FARE_W = 16'(BASE_FARE);
  localparam logic [15:0]    BASE_DIST_W = 16'(BASE_DIST);
  localparam logic [15:0]    PER_UNIT_W  = 16'(PER_UNIT_FARE);
  localparam logic [15:0]    WAIT_FARE_W = 16'(WAIT_FARE);
  localparam logic [16:0]    FARE_MAX_W  = 17'(FARE_MAX);
  localparam logic [WCW-1:0] WAIT_LAST   = WCW'(WAIT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, TRIP, HOLD} state_t;

  state_t         state, state_nxt;
  logic [15:0]    billed_pos, billed_pos_nxt;
  logic [15:0]    fare_nxt, trip_dist_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;

  // Fare clamps at the display ceiling instead of wrapping.
  function automatic logic [15:0] fare_add(input logic [15:0] f, input logic [15:0] inc);
    logic [16:0] s;
    s = {1'b0, f} + {1'b0, inc};
    if (s > FARE_MAX_W) s = FARE_MAX_W;
    return s[15:0];
  endfunction

  always_ff @(posedge clk or negedge restart_n) begin
    if (!restart_n) begin
      state      <= IDLE;
      billed_pos <= '0;
      fare       <= '0;
      trip_dist  <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      billed_pos <= billed_pos_nxt;
      fare       <= fare_nxt;
      trip_dist  <= trip_dist_nxt;
      wait_cnt   <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    billed_pos_nxt = billed_pos;
    fare_nxt       = fare;
    trip_dist_nxt  = trip_dist;
    wait_cnt_nxt   = wait_cnt;
    if (new_trip) begin
      // Restart from any state; odometer motion before this point is not billed.
      state_nxt      = TRIP;
      fare_nxt       = BASE_FARE_W;
      trip_dist_nxt  = '0;
      wait_cnt_nxt   = '0;
      billed_pos_nxt = distance;
    end else begin
      case (state)
        TRIP: begin
          if (end_trip) begin
            state_nxt      = HOLD;
            billed_pos_nxt = distance;
          end else if (billed_pos != distance) begin
            billed_pos_nxt = billed_pos + 16'd1;
            if (trip_dist != 16'hFFFF) trip_dist_nxt = trip_dist + 16'd1;
            if (trip_dist_nxt > BASE_DIST_W) fare_nxt = fare_add(fare, PER_UNIT_W);
          end else if (park) begin
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt_nxt = '0;
              fare_nxt     = fare_add(fare, WAIT_FARE_W);
            end else begin
              wait_cnt_nxt = wait_cnt + WCW'(1);
            end
          end
        end
        IDLE, HOLD: billed_pos_nxt = distance;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  assign in_trip = (state == TRIP);

endmodule

// File: tb/tb_calculate_fare_sub.sv
// Directed bench for calculate_fare_sub: table of single-cycle vectors plus
// hand-written multi-cycle sequences (bursts, waiting, wrap, saturation, reset).
module tb_calculate_fare_sub;

  logic        clk;
  logic        restart_n;
  logic        park;
  logic        new_trip;
  logic        end_trip;
  logic [15:0] distance;
  logic [15:0] fare;
  logic [15:0] trip_dist;
  logic        in_trip;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        nt;
    logic        et;
    logic        pk;
    logic [15:0] d;
    logic [15:0] ef;
    logic [15:0] etd;
    logic        ei;
  } vec_t;

  vec_t vt[$];

  calculate_fare_sub dut (
    .clk       (clk),
    .restart_n (restart_n),
    .park      (park),
    .new_trip  (new_trip),
    .end_trip  (end_trip),
    .distance  (distance),
    .fare      (fare),
    .trip_dist (trip_dist),
    .in_trip   (in_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic nt, input logic et, input logic pk,
                              input int d, input int ef, input int etd, input logic ei);
    vec_t v;
    v.nt = nt; v.et = et; v.pk = pk;
    v.d = 16'(d); v.ef = 16'(ef); v.etd = 16'(etd); v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input int ef, input int etd, input logic ei);
    chk({tag, " fare"}, fare, 16'(ef));
    chk({tag, " trip_dist"}, trip_dist, 16'(etd));
    chk({tag, " in_trip"}, {15'd0, in_trip}, {15'd0, ei});
  endtask

  initial begin
    // Table: trip start, 0..30 included, first paid units, new+end together,
    // end to HOLD, frozen HOLD, re-entry without billing earlier motion.
    vt.push_back(mk(1, 0, 0, 0, 100, 0, 1));
    for (int i = 1; i <= 30; i++) vt.push_back(mk(0, 0, 0, i, 100, i, 1));
    vt.push_back(mk(0, 0, 0, 31, 102, 31, 1));
    vt.push_back(mk(0, 0, 0, 32, 104, 32, 1));
    vt.push_back(mk(1, 1, 0, 32, 100, 0, 1));
    vt.push_back(mk(0, 0, 0, 33, 100, 1, 1));
    vt.push_back(mk(0, 1, 0, 33, 100, 1, 0));
    vt.push_back(mk(0, 0, 1, 50, 100, 1, 0));
    vt.push_back(mk(1, 0, 0, 50, 100, 0, 1));

    restart_n = 1'b0;
    park = 1'b0; new_trip = 1'b0; end_trip = 1'b0; distance = 16'd0;
    #12;
    chk_all("reset", 0, 0, 1'b0);
    @(negedge clk);
    restart_n = 1'b1;
    tick(2);
    chk_all("idle", 0, 0, 1'b0);

    foreach (vt[i]) begin
      new_trip = vt[i].nt; end_trip = vt[i].et; park = vt[i].pk; distance = vt[i].d;
      tick(1);
      chk_all($sformatf("row%0d", i), int'(vt[i].ef), int'(vt[i].etd), vt[i].ei);
    end
    new_trip = 1'b0; end_trip = 1'b0; park = 1'b0;

    // 40-unit burst then a 5-unit jump, one unit billed per cycle.
    distance = 16'd90;
    tick(40);
    chk_all("burst40", 120, 40, 1'b1);
    distance = 16'd95;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk_all($sformatf("jump5 step%0d", i), 120 + 2 * i, 40 + i, 1'b1);
    end
    tick(1);
    chk_all("jump5 settled", 130, 45, 1'b1);

    // Parked waiting: one charge per 1000 cycles.
    park = 1'b1;
    tick(999);
    chk("wait 999 fare", fare, 16'd130);
    tick(1);
    chk("wait 1000 fare", fare, 16'd131);
    tick(2000);
    chk("wait 3000 fare", fare, 16'd133);
    tick(1500);
    chk("wait 1500 fare", fare, 16'd134);
    park = 1'b0;
    tick(100);
    chk("unparked fare", fare, 16'd134);
    park = 1'b1;
    tick(499);
    chk("resume 499 fare", fare, 16'd134);
    tick(1);
    chk("resume 500 fare", fare, 16'd135);
    park = 1'b0;

    // Odometer wrap FFFE -> 0001 is three ordinary units.
    new_trip = 1'b1; distance = 16'hFFFE;
    tick(1);
    new_trip = 1'b0;
    chk_all("wrap start", 100, 0, 1'b1);
    distance = 16'h0001;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("wrap td%0d", i), trip_dist, 16'(i));
    end
    tick(2);
    chk_all("wrap settled", 100, 3, 1'b1);

    // Drive fare to 9998 by distance, then saturate at 9999.
    distance = 16'd4977;
    tick(4976);
    chk_all("sat 9998", 9998, 4979, 1'b1);
    distance = 16'd4979;
    tick(1);
    chk_all("sat step1", 9999, 4980, 1'b1);
    tick(1);
    chk_all("sat step2", 9999, 4981, 1'b1);
    park = 1'b1;
    tick(1000);
    chk("sat wait fare", fare, 16'd9999);
    park = 1'b0;
    end_trip = 1'b1;
    tick(1);
    end_trip = 1'b0;
    chk_all("sat end", 9999, 4981, 1'b0);
    distance = 16'd6000; park = 1'b1;
    tick(1200);
    chk_all("hold frozen", 9999, 4981, 1'b0);
    park = 1'b0;

    // Asynchronous reset mid-trip clears without a clock edge.
    new_trip = 1'b1;
    tick(1);
    new_trip = 1'b0;
    distance = 16'd6003;
    tick(3);
    chk_all("pre-reset", 100, 3, 1'b1);
    #2;
    restart_n = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 1'b0);
    @(negedge clk);
    restart_n = 1'b1;
    distance = 16'd6010;
    tick(2);
    chk_all("post reset idle", 0, 0, 1'b0);
    new_trip = 1'b1; end_trip = 1'b1;
    tick(1);
    new_trip = 1'b0; end_trip = 1'b0;
    chk_all("new+end", 100, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
